fifo_frame_drain: RTL

Downstream consumer of the show-ahead fifo. The fifo presents the head word on its dataout whenever it is non-empty, and a pull advances it at the next clock edge.
- Drains words into fixed-length frames: header, FRAME_LEN data words, XOR-checksum trailer.
- Emits frames on a valid/ready stream toward the packet sink.
- Pads short frames with zero words after an input-starvation timeout.

---
 rtl/fifo_frame_drain.sv | 138 +++++++++++++
 1 files changed

// File: rtl/fifo_frame_drain.sv
// Drains a show-ahead fifo into fixed-length frames: header, FRAME_LEN data words, XOR trailer.
// Starved frames are padded with zero words once the fifo has been empty for TIMEOUT cycles.
module fifo_frame_drain #(
  parameter int BUSW      = 32,
  parameter int FRAME_LEN = 8,
  parameter int TIMEOUT   = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic [BUSW-1:0] fifo_dataout,
  input  logic            fifo_empty,
  output logic            fifo_pull,
  output logic [BUSW-1:0] out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_sof,
  output logic            out_eof,
  output logic [15:0]     frame_cnt
);

  typedef enum logic [2:0] {IDLE, HDR, DATA, PAD, CSUM} state_t;

  localparam int             TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]  TMAX = TW'(TIMEOUT - 1);
  localparam logic [7:0]     LAST = 8'(FRAME_LEN - 1);

  state_t          state, state_n;
  logic [7:0]      seq, seq_n;
  logic [7:0]      wcnt, wcnt_n;
  logic [TW-1:0]   tcnt, tcnt_n;
  logic [BUSW-1:0] csum, csum_n;
  logic [BUSW-1:0] load_data;
  logic            load, load_sof, load_eof;
  logic            free;

  // The output register can take a new word when empty or being drained this cycle.
  assign free = !out_valid || out_ready;

  always_comb begin
    state_n   = state;
    seq_n     = seq;
    wcnt_n    = wcnt;
    tcnt_n    = tcnt;
    csum_n    = csum;
    load      = 1'b0;
    load_data = '0;
    load_sof  = 1'b0;
    load_eof  = 1'b0;
    fifo_pull = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          wcnt_n = '0;
          csum_n = '0;
          tcnt_n = '0;
          if (enable && !fifo_empty) state_n = HDR;
        end
        HDR: begin
          if (free) begin
            load            = 1'b1;
            load_data[31:0] = {16'hA5C3, seq, 8'(FRAME_LEN)};
            load_sof        = 1'b1;
            state_n         = DATA;
          end
        end
        DATA: begin
          // Starvation only counts while the fifo is empty, never during sink backpressure.
          if (!fifo_empty) begin
            if (free) begin
              fifo_pull = 1'b1;
              load      = 1'b1;
              load_data = fifo_dataout;
              csum_n    = csum ^ fifo_dataout;
              wcnt_n    = wcnt + 8'd1;
              tcnt_n    = '0;
              if (wcnt == LAST) state_n = CSUM;
            end
          end else if (tcnt == TMAX) begin
            state_n = PAD;
          end else begin
            tcnt_n = tcnt + TW'(1);
          end
        end
        PAD: begin
          if (free) begin
            load   = 1'b1;
            wcnt_n = wcnt + 8'd1;
            if (wcnt == LAST) state_n = CSUM;
          end
        end
        CSUM: begin
          if (free) begin
            load      = 1'b1;
            load_data = csum;
            load_eof  = 1'b1;
            seq_n     = seq + 8'd1;
            state_n   = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      seq       <= '0;
      wcnt      <= '0;
      tcnt      <= '0;
      csum      <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
      frame_cnt <= '0;
    end else begin
      state <= state_n;
      seq   <= seq_n;
      wcnt  <= wcnt_n;
      tcnt  <= tcnt_n;
      csum  <= csum_n;
      if (load) begin
        out_data  <= load_data;
        out_sof   <= load_sof;
        out_eof   <= load_eof;
        out_valid <= 1'b1;
      end else if (free) begin
        out_valid <= 1'b0;
        out_sof   <= 1'b0;
        out_eof   <= 1'b0;
      end
      if (out_valid && out_ready && out_eof) frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule
